// File: rtl/countdown_timer_if.sv
// Bundles the countdown timer's control inputs, digit readout and seven-segment outputs.
interface countdown_timer_if;
  logic        load;
  logic        run;
  logic [23:0] preset_bcd;
  logic [23:0] bcd_out;
  logic        done;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
  logic [6:0]  HEX2;
  logic [6:0]  HEX3;
  logic [6:0]  HEX4;
  logic [6:0]  HEX5;

  modport master (
    output load, run, preset_bcd,
    input  bcd_out, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  load, run, preset_bcd,
    output bcd_out, done, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD MM:SS:hh countdown timer with its own 10 ms prescaler and a blinking display once zero is reached.
module countdown_timer #(
  parameter int unsigned TICK_DIV    = 500000,
  parameter int unsigned BLINK_TICKS = 50
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  countdown_timer_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int BW = $clog2(BLINK_TICKS) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [23:0]   digits_q, digits_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          blank_q, blank_d;
  logic          tick;
  logic [23:0]   preset_clamped;
  logic [23:0]   digits_dec;

  // Digits above 9 saturate to 9; seconds-tens saturates to 5.
  function automatic logic [23:0] clamp_bcd(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    for (int i = 0; i < 6; i++) begin
      if (r[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    if (r[15:12] > 4'd5) r[15:12] = 4'd5;
    return r;
  endfunction

  // One-hundredth decrement with a BCD/sexagesimal borrow chain; zero stays zero.
  function automatic logic [23:0] dec_bcd(input logic [23:0] v);
    logic [23:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    if (v != 24'h0) begin
      for (int i = 0; i < 6; i++) begin
        if (borrow) begin
          if (r[i*4 +: 4] == 4'd0) begin
            r[i*4 +: 4] = (i == 3) ? 4'd5 : 4'd9;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
            borrow      = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Active-low seven-segment pattern, bit 6 = g, bit 0 = a.
  function automatic logic [6:0] seg7(input logic [3:0] d, input logic blank);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return blank ? 7'h7F : s;
  endfunction

  assign tick           = (presc_q == PRESC_LAST);
  assign preset_clamped = clamp_bcd(bus.preset_bcd);
  assign digits_dec     = dec_bcd(digits_q);

  // Next-state logic: load overrides everything, then per-state run/tick handling.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    presc_d  = presc_q;
    blink_d  = blink_q;
    blank_d  = blank_q;
    if (bus.load) begin
      digits_d = preset_clamped;
      presc_d  = '0;
      blink_d  = '0;
      blank_d  = 1'b0;
      state_d  = (preset_clamped == 24'h0) ? S_IDLE : S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (bus.run) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          if (!bus.run) begin
            state_d = S_ARMED;
            presc_d = '0;
          end else if (tick) begin
            presc_d  = '0;
            digits_d = digits_dec;
            if (digits_dec == 24'h0) begin
              state_d = S_DONE;
              blink_d = '0;
              blank_d = 1'b0;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_DONE: begin
          if (tick) begin
            presc_d = '0;
            if (blink_q == BLINK_LAST) begin
              blink_d = '0;
              blank_d = ~blank_q;
            end else begin
              blink_d = blink_q + 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous reset to an idle, zeroed, visible display.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      digits_q <= '0;
      presc_q  <= '0;
      blink_q  <= '0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      presc_q  <= presc_d;
      blink_q  <= blink_d;
      blank_q  <= blank_d;
    end
  end

  assign bus.bcd_out = digits_q;
  assign bus.done    = (state_q == S_DONE);
  assign bus.HEX0    = seg7(digits_q[3:0],   blank_q);
  assign bus.HEX1    = seg7(digits_q[7:4],   blank_q);
  assign bus.HEX2    = seg7(digits_q[11:8],  blank_q);
  assign bus.HEX3    = seg7(digits_q[15:12], blank_q);
  assign bus.HEX4    = seg7(digits_q[19:16], blank_q);
  assign bus.HEX5    = seg7(digits_q[23:20], blank_q);
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a time-in-hundredths reference model checked every cycle.
module tb_countdown_timer;
  localparam int TD = 4;
  localparam int BT = 2;

  logic clk;
  logic rst;
  int   nvec;
  int   nerr;

  countdown_timer_if bus();

  countdown_timer #(.TICK_DIV(TD), .BLINK_TICKS(BT)) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: value in hundredths, mode, and cycles elapsed in the current mode.
  int m_mode;   // 0 idle, 1 armed, 2 run, 3 done
  int m_val;
  int m_el;

  function automatic int preset_to_hund(input logic [23:0] p);
    int d[6];
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(p[i*4 +: 4]);
      if (d[i] > 9) d[i] = 9;
    end
    if (d[3] > 5) d[3] = 5;
    return ((d[5] * 10 + d[4]) * 60 + d[3] * 10 + d[2]) * 100 + d[1] * 10 + d[0];
  endfunction

  function automatic logic [23:0] hund_to_bcd(input int v);
    int h, s, m;
    logic [23:0] r;
    h = v % 100;
    s = (v / 100) % 60;
    m = v / 6000;
    r = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_val = 0; m_el = 0;
    end else if (bus.load) begin
      m_val  = preset_to_hund(bus.preset_bcd);
      m_mode = (m_val == 0) ? 0 : 1;
      m_el   = 0;
    end else begin
      case (m_mode)
        1: if (bus.run) begin m_mode = 2; m_el = 0; end
        2: begin
          if (!bus.run) begin
            m_mode = 1; m_el = 0;
          end else begin
            m_el++;
            if (m_el % TD == 0) begin
              m_val--;
              if (m_val == 0) begin m_mode = 3; m_el = 0; end
            end
          end
        end
        3: m_el++;
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled just after the active edge.
  always @(posedge clk) begin
    logic [23:0] eb;
    logic        blank;
    logic [41:0] eh;
    #1;
    eb    = hund_to_bcd(m_val);
    blank = (m_mode == 3) && (((m_el / (TD * BT)) % 2) == 1);
    for (int i = 0; i < 6; i++)
      eh[i*7 +: 7] = blank ? 7'h7F : seg_of(eb[i*4 +: 4]);
    chk("model bcd_out", 48'(bus.bcd_out), 48'(eb));
    chk("model done", 48'(bus.done), 48'(m_mode == 3));
    chk("model HEX", 48'({bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}), 48'(eh));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [23:0] p);
    bus.load       = 1'b1;
    bus.preset_bcd = p;
    @(negedge clk);
    bus.load       = 1'b0;
  endtask

  task automatic chk_all_zero_shown(input string nm);
    chk({nm, " bcd"}, 48'(bus.bcd_out), 48'h0);
    chk({nm, " done"}, 48'(bus.done), 48'h0);
    chk({nm, " hex"}, 48'({bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}),
        48'({6{7'h40}}));
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst = 1'b1;
    bus.load = 1'b0; bus.run = 1'b0; bus.preset_bcd = '0;
    cyc(2);
    rst = 1'b0;
    chk_all_zero_shown("reset");

    // run is ignored in IDLE
    bus.run = 1'b1;
    cyc(20);
    chk_all_zero_shown("idle run");
    bus.run = 1'b0;

    // short countdown
    do_load(24'h000003);
    bus.run = 1'b1;
    cyc(1);
    cyc(4); chk("cd 02", 48'(bus.bcd_out), 48'h000002);
    cyc(4); chk("cd 01", 48'(bus.bcd_out), 48'h000001);
    chk("cd 01 done", 48'(bus.done), 48'h0);
    cyc(4); chk("cd 00", 48'(bus.bcd_out), 48'h000000);
    chk("cd done", 48'(bus.done), 48'h1);
    bus.run = 1'b0;

    // blink: 8 shown, 8 blank, shown again
    cyc(7); chk("blink shown end", 48'(bus.HEX0), 48'h40);
    cyc(1); chk("blink blank start", 48'(bus.HEX3), 48'h7F);
    cyc(7); chk("blink blank end", 48'(bus.HEX5), 48'h7F);
    cyc(1); chk("blink shown again", 48'(bus.HEX0), 48'h40);
    do_load(24'h000500);
    chk("reload done", 48'(bus.done), 48'h0);
    chk("reload HEX2", 48'(bus.HEX2), 48'h12);
    cyc(3); chk("armed holds", 48'(bus.bcd_out), 48'h000500);

    // borrow chain and clamp
    do_load(24'h100000);
    bus.run = 1'b1;
    cyc(1); cyc(4);
    chk("borrow chain", 48'(bus.bcd_out), 48'h095999);
    bus.run = 1'b0;
    do_load(24'hFF7CA3);
    chk("clamp", 48'(bus.bcd_out), 48'h995993);

    // pause and resume
    do_load(24'h000010);
    bus.run = 1'b1;
    cyc(1); cyc(4);
    chk("pause first dec", 48'(bus.bcd_out), 48'h000009);
    cyc(2);
    bus.run = 1'b0;
    cyc(10); chk("pause hold", 48'(bus.bcd_out), 48'h000009);
    bus.run = 1'b1;
    cyc(1); cyc(3);
    chk("resume not yet", 48'(bus.bcd_out), 48'h000009);
    cyc(1); chk("resume dec", 48'(bus.bcd_out), 48'h000008);

    // load on a tick edge wins over the decrement
    do_load(24'h000050);
    cyc(1); cyc(3);
    do_load(24'h000020);
    chk("load beats tick", 48'(bus.bcd_out), 48'h000020);
    cyc(4); chk("after load hold", 48'(bus.bcd_out), 48'h000020);
    cyc(1); chk("after load dec", 48'(bus.bcd_out), 48'h000019);

    // reset mid-count
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk_all_zero_shown("mid reset");
    rst = 1'b0;
    bus.run = 1'b0;

    // 00:00:01 reaches DONE exactly one interval after RUN entry
    do_load(24'h000001);
    bus.run = 1'b1;
    cyc(1); cyc(3);
    chk("one hund pending", 48'(bus.done), 48'h0);
    cyc(1);
    chk("one hund done", 48'(bus.done), 48'h1);
    chk("one hund zero", 48'(bus.bcd_out), 48'h0);

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
